rr_priority_encoder: RTL

//   Parametrised N-to-log2(N) encoder with a registered output stage and a

---
 rtl/rr_priority_encoder_if.sv | 21 ++
 rtl/rr_priority_encoder.sv | 64 ++++++
 2 files changed

// File: rtl/rr_priority_encoder_if.sv
// rr_priority_encoder_if: request-in / index-out valid-ready bundle.
interface rr_priority_encoder_if #(parameter int N = 8);
  localparam int W = $clog2(N);
  logic         in_valid;
  logic [N-1:0] in_req;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_index;
  logic [N-1:0] out_onehot;
  logic         out_none;
  logic         out_multi;
  logic         out_ready;
  modport master (
    output in_valid, in_req, out_ready,
    input  in_ready, out_valid, out_index, out_onehot, out_none, out_multi
  );
  modport slave (
    input  in_valid, in_req, out_ready,
    output in_ready, out_valid, out_index, out_onehot, out_none, out_multi
  );
endinterface

// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder: registered N-to-log2(N) encoder, fixed-priority or round-robin.
module rr_priority_encoder #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input logic clk,
  input logic rst,
  rr_priority_encoder_if.slave bus
);
  localparam int W = $clog2(N);
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_index_q, out_index_d;
  logic [N-1:0] out_onehot_q, out_onehot_d;
  logic         out_none_q, out_none_d;
  logic         out_multi_q, out_multi_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] sel, j;
  logic         none, multi, in_ready, accept;
  // Scan order position k maps to a request line; rotated by ptr in round-robin.
  function automatic int rot(input int k, input logic [W-1:0] p);
    return (MODE != 0) ? (int'(p) + k) % N : k;
  endfunction
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  always_comb begin
    sel = '0;
    j   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = W'(rot(k, ptr_q));
      if (bus.in_req[j]) sel = j;
    end
    none         = ~|bus.in_req;
    multi        = |(bus.in_req & (bus.in_req - N'(1)));
    out_valid_d  = accept ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
    out_index_d  = accept ? (none ? '0 : sel) : out_index_q;
    out_onehot_d = accept ? (none ? '0 : N'(1) << sel) : out_onehot_q;
    out_none_d   = accept ? none : out_none_q;
    out_multi_d  = accept ? multi : out_multi_q;
    ptr_d        = (MODE != 0 && accept && !none) ? ((sel == W'(N - 1)) ? '0 : sel + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_index_q  <= '0;
      out_onehot_q <= '0;
      out_none_q   <= 1'b0;
      out_multi_q  <= 1'b0;
      ptr_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_index_q  <= out_index_d;
      out_onehot_q <= out_onehot_d;
      out_none_q   <= out_none_d;
      out_multi_q  <= out_multi_d;
      ptr_q        <= ptr_d;
    end
  end
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_index  = out_index_q;
  assign bus.out_onehot = out_onehot_q;
  assign bus.out_none   = out_none_q;
  assign bus.out_multi  = out_multi_q;
endmodule
